// File: rtl/lfsr_prbs_gen_multi_if.sv
// Word stream carrying PRBS data from the generator to its sink.
// The master drives data and valid; the slave answers with ready.
interface lfsr_prbs_gen_multi_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/lfsr_prbs_gen_multi.sv
// Runtime-selectable PRBS7/9/15/23/31 generator (Fibonacci, MSB-first).
// It produces DATA_WIDTH bits per word and offers each word on a valid/ready stream.
// It also supports seed load, pause/resume, single-bit error injection and word/error counters.
module lfsr_prbs_gen_multi #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [2:0]  INIT_MODE  = 3'd4,
    parameter logic [30:0] INIT_SEED  = 31'h7FFFFFFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [2:0]                   mode,
    input  logic                         load,
    input  logic [30:0]                  seed,
    input  logic                         err_inject,
    output logic [31:0]                  word_count,
    output logic [15:0]                  err_count,
    lfsr_prbs_gen_multi_if.master        stream
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Register mask for the LFSR length of a mode; the clock-pattern modes use no LFSR bits.
    function automatic logic [30:0] len_mask(input logic [2:0] m);
        logic [30:0] r;
        case (m)
            3'd0:    r = 31'h0000007F;
            3'd1:    r = 31'h000001FF;
            3'd2:    r = 31'h00007FFF;
            3'd3:    r = 31'h007FFFFF;
            3'd4:    r = 31'h7FFFFFFF;
            default: r = 31'h00000000;
        endcase
        return r;
    endfunction

    // Trim a seed to the mode length and replace the all-zero lockup state with all-ones.
    function automatic logic [30:0] fix_seed(input logic [30:0] s, input logic [2:0] m);
        logic [30:0] masked;
        masked = s & len_mask(m);
        if (masked == 31'h00000000) begin
            masked = len_mask(m);
        end
        return masked;
    endfunction

    // Feedback bit of the selected polynomial; this bit is also the output bit.
    function automatic logic tap_bit(input logic [30:0] s, input logic [2:0] m);
        logic r;
        case (m)
            3'd0:    r = s[6]  ^ s[5];
            3'd1:    r = s[8]  ^ s[4];
            3'd2:    r = s[14] ^ s[13];
            3'd3:    r = s[22] ^ s[17];
            3'd4:    r = s[30] ^ s[27];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [30:0]             lfsr_r;
    logic [2:0]              mode_q_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic                    valid_r;
    logic [31:0]             word_count_r;
    logic [15:0]             err_count_r;
    logic                    pending_r;
    logic                    word_err_r;

    logic                    hs_s;
    logic                    gen_s;
    logic                    drop_s;
    logic [2:0]              gen_mode_s;
    logic [30:0]             walk_s;
    logic [30:0]             gen_lfsr_s;
    logic [DATA_WIDTH-1:0]   prbs_word_s;
    logic [DATA_WIDTH-1:0]   clk_word_s;
    logic [DATA_WIDTH-1:0]   gen_word_s;
    logic                    fb_s;

    assign stream.data_out   = data_r;
    assign stream.data_valid = valid_r;
    assign word_count        = word_count_r;
    assign err_count         = err_count_r;

    // Next-word generator: walks the LFSR DATA_WIDTH steps, first bit lands in the MSB.
    always_comb begin
        gen_mode_s  = (state_r == ST_IDLE) ? mode : mode_q_r;
        walk_s      = fix_seed(lfsr_r, gen_mode_s);
        prbs_word_s = '0;
        clk_word_s  = '0;
        fb_s        = 1'b0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb_s           = tap_bit(walk_s, gen_mode_s);
            walk_s         = {walk_s[29:0], fb_s} & len_mask(gen_mode_s);
            prbs_word_s[i] = fb_s;
            clk_word_s[i]  = (((DATA_WIDTH - 1 - i) % 2) == 0);
        end
        if (gen_mode_s < 3'd5) begin
            gen_lfsr_s = walk_s;
            gen_word_s = prbs_word_s;
        end else begin
            gen_lfsr_s = lfsr_r;
            gen_word_s = clk_word_s;
        end
        gen_word_s[0] = gen_word_s[0] ^ pending_r;
    end

    // Next-state logic: decides when a new word is generated or the stream goes quiet.
    always_comb begin
        state_next_s = state_r;
        gen_s        = 1'b0;
        drop_s       = 1'b0;
        hs_s         = valid_r && stream.data_ready;
        if (load) begin
            state_next_s = enable ? ST_RUN : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_next_s = ST_RUN;
                        gen_s        = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!valid_r || hs_s) begin
                        if (enable) begin
                            gen_s = 1'b1;
                        end else begin
                            state_next_s = ST_IDLE;
                            drop_s       = 1'b1;
                        end
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath registers: LFSR, output word, counters and error-injection bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_r       <= fix_seed(INIT_SEED, INIT_MODE);
            mode_q_r     <= INIT_MODE;
            data_r       <= '0;
            valid_r      <= 1'b0;
            word_count_r <= 32'd0;
            err_count_r  <= 16'd0;
            pending_r    <= 1'b0;
            word_err_r   <= 1'b0;
        end else if (load) begin
            // Load discards any word on offer, even one being accepted right now.
            lfsr_r       <= fix_seed(seed, mode);
            mode_q_r     <= mode;
            data_r       <= '0;
            valid_r      <= 1'b0;
            word_count_r <= 32'd0;
            err_count_r  <= 16'd0;
            pending_r    <= 1'b0;
            word_err_r   <= 1'b0;
        end else begin
            if (gen_s) begin
                lfsr_r     <= gen_lfsr_s;
                data_r     <= gen_word_s;
                valid_r    <= 1'b1;
                word_err_r <= pending_r;
                // A pulse landing while an error is still pending merges with it.
                pending_r  <= err_inject & ~pending_r;
                if (state_r == ST_IDLE) begin
                    mode_q_r <= mode;
                end
            end else begin
                pending_r <= pending_r | err_inject;
                if (drop_s) begin
                    valid_r <= 1'b0;
                end
            end
            if (hs_s) begin
                word_count_r <= word_count_r + 32'd1;
                if (word_err_r && (err_count_r != 16'hFFFF)) begin
                    err_count_r <= err_count_r + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_gen_multi.sv
// Self-checking bench for lfsr_prbs_gen_multi (DATA_WIDTH=8, PRBS9 out of reset).
// The reference is a bit-serial LFSR model that advances once per accepted word.
module tb_lfsr_prbs_gen_multi;

    localparam int DW = 8;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [2:0]  mode;
    logic        load;
    logic [30:0] seed;
    logic        err_inject;
    logic [31:0] word_count;
    logic [15:0] err_count;

    lfsr_prbs_gen_multi_if #(.DATA_WIDTH(DW)) bif ();

    lfsr_prbs_gen_multi #(
        .DATA_WIDTH (DW),
        .INIT_MODE  (3'd1),
        .INIT_SEED  (31'h7FFFFFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .load       (load),
        .seed       (seed),
        .err_inject (err_inject),
        .word_count (word_count),
        .err_count  (err_count),
        .stream     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     tests    = 0;
    int     fails    = 0;
    int     sb_count = 0;
    int     flip_idx = -1;
    longint m_state  = 0;
    int     m_mode   = 0;
    bit     cap_en   = 1'b0;
    logic [DW-1:0] cap[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int len_of(input int m);
        case (m)
            0:       return 7;
            1:       return 9;
            2:       return 15;
            3:       return 23;
            default: return 31;
        endcase
    endfunction

    function automatic int tap_of(input int m);
        case (m)
            0:       return 6;
            1:       return 5;
            2:       return 14;
            3:       return 18;
            default: return 28;
        endcase
    endfunction

    task automatic model_load(input logic [30:0] s, input int m);
        longint mask;
        m_mode = m;
        if (m < 5) begin
            mask    = (longint'(1) << len_of(m)) - 1;
            m_state = longint'(s) & mask;
            if (m_state == 0) m_state = mask;
        end
    endtask

    task automatic model_next(output logic [DW-1:0] w);
        longint mask;
        longint b;
        int     n;
        int     t;
        w = '0;
        if (m_mode >= 5) begin
            for (int k = 0; k < DW; k++) w[DW-1-k] = ((k % 2) == 0);
        end else begin
            n    = len_of(m_mode);
            t    = tap_of(m_mode);
            mask = (longint'(1) << n) - 1;
            for (int k = 0; k < DW; k++) begin
                b       = ((m_state >> (n - 1)) ^ (m_state >> (t - 1))) & 1;
                m_state = ((m_state << 1) | b) & mask;
                w[DW-1-k] = b[0];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs the stream until n words are accepted, checking each against the model
    // and checking that a word on offer stays put while the sink stalls.
    task automatic stream_words(input int n, input bit rand_bp, input bit rand_en);
        int            got;
        int            cyc;
        logic          held_v;
        logic [DW-1:0] held_d;
        logic [DW-1:0] exp;
        got    = 0;
        cyc    = 0;
        held_v = 1'b0;
        held_d = '0;
        while (got < n && cyc < n * 8 + 100) begin
            if (held_v) begin
                check("hold_valid", 64'(bif.data_valid), 64'd1);
                check("hold_data", 64'(bif.data_out), 64'(held_d));
            end
            bif.data_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            enable         = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bif.data_valid && bif.data_ready) begin
                model_next(exp);
                if (got == flip_idx) exp[0] = ~exp[0];
                check("word", 64'(bif.data_out), 64'(exp));
                if (cap_en) cap.push_back(bif.data_out);
                got++;
                sb_count++;
            end
            held_v = bif.data_valid && !bif.data_ready;
            held_d = bif.data_out;
            step();
            cyc++;
        end
        check("stream_timeout", 64'(got), 64'(n));
    endtask

    task automatic do_load(input logic [30:0] s, input logic [2:0] m, input logic inj);
        seed           = s;
        mode           = m;
        load           = 1'b1;
        err_inject     = inj;
        step();
        load           = 1'b0;
        err_inject     = 1'b0;
        model_load(s, int'(m));
        sb_count       = 0;
    endtask

    initial begin
        logic [30:0] rs;
        int          nw;
        rst            = 1'b0;
        enable         = 1'b0;
        mode           = 3'd1;
        load           = 1'b0;
        seed           = 31'd0;
        err_inject     = 1'b0;
        bif.data_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_valid", 64'(bif.data_valid), 64'd0);
        check("rst_data", 64'(bif.data_out), 64'd0);
        check("rst_wcount", 64'(word_count), 64'd0);
        check("rst_ecount", 64'(err_count), 64'd0);
        enable = 1'b1;
        load   = 1'b1;
        seed   = 31'h5;
        step();
        check("rst_over_load", 64'(bif.data_valid), 64'd0);
        load = 1'b0;

        // T1: PRBS9 from all-ones, 8-bit words, period of 511 words
        rst = 1'b1;
        model_load(31'h7FFFFFFF, 1);
        sb_count = 0;
        cap.delete();
        cap_en = 1'b1;
        stream_words(520, 1'b0, 1'b0);
        cap_en = 1'b0;
        check("t1_word0", 64'(cap[0]), 64'h07);
        check("t1_word1", 64'(cap[1]), 64'hBE);
        for (int k = 0; k < 9; k++) check("t1_period", 64'(cap[511 + k]), 64'(cap[k]));
        check("t1_wcount", 64'(word_count), 64'(sb_count));

        // T2: every PRBS mode over a full period (short ones) or 10k words
        for (int m = 0; m < 5; m++) begin
            nw = (m == 0) ? 16 : (m == 1) ? 64 : (m == 2) ? 4096 : 10000;
            rs = 31'($urandom);
            bif.data_ready = 1'b1;
            do_load(rs, 3'(m), 1'b0);
            check("t2_wcount_load", 64'(word_count), 64'd0);
            if (m == 3) mode = 3'd0;
            stream_words(nw, 1'b0, 1'b0);
            check("t2_wcount", 64'(word_count), 64'(sb_count));
        end
        do_load(31'h1234, 3'd5, 1'b0);
        stream_words(6, 1'b0, 1'b0);

        // T3: random backpressure with enable toggling
        do_load(31'($urandom), 3'd2, 1'b0);
        stream_words(400, 1'b1, 1'b1);
        check("t3_wcount", 64'(word_count), 64'(sb_count));
        enable = 1'b1;

        // T4: zero-seed PRBS7 load while the sink stalls
        bif.data_ready = 1'b0;
        step();
        step();
        check("t4_valid_held", 64'(bif.data_valid), 64'd1);
        do_load(31'd0, 3'd0, 1'b0);
        check("t4_valid_drop", 64'(bif.data_valid), 64'd0);
        check("t4_wcount", 64'(word_count), 64'd0);
        step();
        check("t4_valid_back", 64'(bif.data_valid), 64'd1);
        check("t4_first_word", 64'(bif.data_out), 64'h02);
        stream_words(20, 1'b0, 1'b0);

        // T5: two back-to-back injections flip exactly one word
        bif.data_ready = 1'b0;
        step();
        err_inject = 1'b1;
        step();
        step();
        err_inject = 1'b0;
        flip_idx   = 1;
        stream_words(4, 1'b0, 1'b0);
        flip_idx   = -1;
        check("t5_ecount", 64'(err_count), 64'd1);
        check("t5_wcount", 64'(word_count), 64'(sb_count));
        bif.data_ready = 1'b1;
        do_load(31'($urandom), 3'd1, 1'b1);
        check("t5_load_valid", 64'(bif.data_valid), 64'd0);
        check("t5_load_wcount", 64'(word_count), 64'd0);
        check("t5_load_ecount", 64'(err_count), 64'd0);
        stream_words(6, 1'b0, 1'b0);
        check("t5_inject_dropped", 64'(err_count), 64'd0);

        // T6: reset in the middle of a handshake
        mode       = 3'd1;
        err_inject = 1'b1;
        rst        = 1'b0;
        step();
        err_inject = 1'b0;
        check("t6_valid", 64'(bif.data_valid), 64'd0);
        check("t6_data", 64'(bif.data_out), 64'd0);
        check("t6_wcount", 64'(word_count), 64'd0);
        check("t6_ecount", 64'(err_count), 64'd0);
        rst = 1'b1;
        model_load(31'h7FFFFFFF, 1);
        sb_count = 0;
        stream_words(8, 1'b0, 1'b0);
        check("t6_wcount_after", 64'(word_count), 64'(sb_count));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
